// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared defaults for the prefetch fetch stage: widths, PC step, reset PC and
// the counter-width helper used by the queue and the credit logic.
package fetch_prefetch_queue_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int ADDR_W_DEF   = 16;
    localparam int DEPTH_DEF    = 4;
    localparam int MAX_OUT_DEF  = 2;
    localparam int INC_DEF      = 2;
    localparam int RESET_PC_DEF = 0;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Bundle of the instruction-memory and decode-side signals of the fetch stage.
// master = fetch stage, slave = surrounding core (memory + decode + branch unit).
interface fetch_prefetch_queue_if
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    // Branch / decode control
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              stall;
    // Instruction memory
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    // Decode side
    logic              id_valid;
    logic [DATA_W-1:0] id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic [ADDR_W-1:0] id_pc_next;
    logic              id_halt;
    logic              pc_ovf;

    modport master (
        input  redirect, redirect_pc, stall,
        input  imem_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr,
        output id_valid, id_instr, id_pc, id_pc_next, id_halt, pc_ovf
    );

    modport slave (
        output redirect, redirect_pc, stall,
        output imem_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr,
        input  id_valid, id_instr, id_pc, id_pc_next, id_halt, pc_ovf
    );

endinterface

// File: rtl/fetch_prefetch_queue_fifo.sv
// Synchronous FIFO holding {pc, instr} entries: push/pop/flush, async reset,
// occupancy count. Flush wins over push and pop in the same cycle.
module fetch_prefetch_queue_fifo
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic                    empty,
    output logic [cnt_w(DEPTH)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Next-state for pointers and occupancy.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the count alone says which entries are live, so it can map to plain RAM.
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Prefetching fetch stage: issues sequential requests to an in-order,
// variable-latency instruction memory, buffers responses for decode, and
// handles redirect flush, halt detection and decode back-pressure.
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int MAX_OUT  = MAX_OUT_DEF,
    parameter int INC      = INC_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input logic                    clk,
    input logic                    rst,
    fetch_prefetch_queue_if.master bus
);
    localparam int OW = cnt_w(MAX_OUT);
    localparam int CW = cnt_w(DEPTH);
    localparam int SW = ((OW > CW) ? OW : CW) + 1;
    localparam int QW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [OW-1:0]     outstanding_q, outstanding_d;
    logic [OW-1:0]     drop_cnt_q, drop_cnt_d;
    logic              halted_q, halted_d;
    logic              pc_ovf_q, pc_ovf_d;

    logic [CW-1:0]     q_count;
    logic              q_empty;
    logic [QW-1:0]     q_head;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_instr;
    logic              credit_ok, issue, push, pop;
    logic [ADDR_W:0]   fetch_inc;

    // Queued entries plus in-flight requests never exceed DEPTH, so every
    // response that is kept has a free slot waiting for it.
    assign credit_ok = (SW'(q_count) + SW'(outstanding_q)) < SW'(DEPTH);
    // Gated by rst so that every output reads 0 while reset is held.
    assign bus.imem_req  = ~rst & ~bus.redirect & ~halted_q
                         & (outstanding_q < OW'(MAX_OUT)) & credit_ok;
    assign bus.imem_addr = fetch_pc_q;
    assign issue         = bus.imem_req & bus.imem_ready;
    assign fetch_inc     = {1'b0, fetch_pc_q} + (ADDR_W + 1)'(INC);
    assign push          = bus.imem_rvalid & ~bus.redirect & (drop_cnt_q == '0);
    assign pop           = ~q_empty & ~bus.stall & ~bus.redirect;

    // Fetch control: PC advance, credit tracking, squash counter and halt.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        halted_d      = halted_q;
        pc_ovf_d      = pc_ovf_q;
        outstanding_d = outstanding_q;
        if (issue && !bus.imem_rvalid)
            outstanding_d = outstanding_q + OW'(1);
        else if (!issue && bus.imem_rvalid && outstanding_q != '0)
            outstanding_d = outstanding_q - OW'(1);
        if (issue) begin
            fetch_pc_d = fetch_inc[ADDR_W-1:0];
            pc_ovf_d   = pc_ovf_q | fetch_inc[ADDR_W];
        end
        if (bus.redirect) begin
            // Everything still in flight belongs to the old path, including
            // this cycle's response, which is discarded outright.
            fetch_pc_d = bus.redirect_pc;
            resp_pc_d  = bus.redirect_pc;
            halted_d   = 1'b0;
            drop_cnt_d = outstanding_d;
        end else if (bus.imem_rvalid) begin
            if (drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - OW'(1);
            end else begin
                resp_pc_d = resp_pc_q + ADDR_W'(INC);
                if (bus.imem_rdata == '0) begin
                    halted_d   = 1'b1;
                    drop_cnt_d = outstanding_d;
                end
            end
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= ADDR_W'(RESET_PC);
            resp_pc_q     <= ADDR_W'(RESET_PC);
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            halted_q      <= 1'b0;
            pc_ovf_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            halted_q      <= halted_d;
            pc_ovf_q      <= pc_ovf_d;
        end
    end

    fetch_prefetch_queue_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect),
        .wdata ({resp_pc_q, bus.imem_rdata}),
        .rdata (q_head),
        .empty (q_empty),
        .count (q_count)
    );

    assign head_pc    = q_head[QW-1:DATA_W];
    assign head_instr = q_head[DATA_W-1:0];

    // Decode outputs are held at 0 when the queue is empty.
    assign bus.id_valid   = ~q_empty;
    assign bus.id_instr   = q_empty ? '0 : head_instr;
    assign bus.id_pc      = q_empty ? '0 : head_pc;
    assign bus.id_pc_next = q_empty ? '0 : head_pc + ADDR_W'(INC);
    assign bus.id_halt    = ~q_empty & (head_instr == '0);
    assign bus.pc_ovf     = pc_ovf_q;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: an in-order memory model with
// programmable latency, and a scoreboard of expected {pc} entries pushed when
// a request is accepted and popped when decode takes an entry.
module tb_fetch_prefetch_queue;

    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_prefetch_queue_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    fetch_prefetch_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] mem [int];
    pend_t         pend [$];
    logic [AW-1:0] sb [$];
    int            cyc, lat, first_valid, n_pops;
    logic          t_rst, t_redirect, t_stall, t_ready;
    logic [AW-1:0] t_rpc, exp_fetch, max_addr;
    logic [AW-1:0] last_pc, last_pc_next;
    logic          last_halt, halt_popped;

    // Program image: instruction at a is (a>>1)+1 unless overridden.
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return (a >> 1) + 16'd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_imem_req"},   32'(bus.imem_req),   0);
        check({tag, "_imem_addr"},  32'(bus.imem_addr),  0);
        check({tag, "_id_valid"},   32'(bus.id_valid),   0);
        check({tag, "_id_instr"},   32'(bus.id_instr),   0);
        check({tag, "_id_pc"},      32'(bus.id_pc),      0);
        check({tag, "_id_pc_next"}, 32'(bus.id_pc_next), 0);
        check({tag, "_id_halt"},    32'(bus.id_halt),    0);
        check({tag, "_pc_ovf"},     32'(bus.pc_ovf),     0);
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, then account
    // for the handshakes that the next rising edge will perform.
    task automatic step();
        logic          rsp;
        logic [AW-1:0] e;
        pend_t         p;
        @(negedge clk);
        cyc++;
        rst             = t_rst;
        bus.redirect    = t_redirect;
        bus.redirect_pc = t_rpc;
        bus.stall       = t_stall;
        bus.imem_ready  = t_ready;
        rsp = 1'b0;
        if (pend.size() > 0) rsp = (pend[0].due <= cyc);
        bus.imem_rvalid = rsp;
        if (rsp) bus.imem_rdata = mem_val(pend[0].addr);
        else     bus.imem_rdata = 16'hDEAD;
        #1;
        if (rsp) void'(pend.pop_front());
        if (halt_popped) begin
            check("post_halt_valid", 32'(bus.id_valid), 0);
            check("post_halt_req",   32'(bus.imem_req), 0);
        end
        if (bus.imem_req && bus.imem_ready) begin
            check("imem_addr", 32'(bus.imem_addr), 32'(exp_fetch));
            p.addr = bus.imem_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
            sb.push_back(exp_fetch);
            if (bus.imem_addr > max_addr) max_addr = bus.imem_addr;
            exp_fetch = exp_fetch + 16'd2;
        end
        if (bus.id_valid && !bus.stall && !bus.redirect) begin
            if (sb.size() == 0) begin
                check("spurious_pop", 32'(bus.id_valid), 0);
            end else begin
                e = sb.pop_front();
                check("id_pc",      32'(bus.id_pc),      32'(e));
                check("id_instr",   32'(bus.id_instr),   32'(mem_val(e)));
                check("id_pc_next", 32'(bus.id_pc_next), 32'(AW'(e + 16'd2)));
                check("id_halt",    32'(bus.id_halt),    32'(mem_val(e) == '0));
                n_pops++;
                last_pc      = bus.id_pc;
                last_pc_next = bus.id_pc_next;
                last_halt    = bus.id_halt;
                if (first_valid < 0) first_valid = cyc;
                if (mem_val(e) == '0) begin
                    halt_popped = 1'b1;
                    sb.delete();
                end
            end
        end
        if (bus.redirect) begin
            sb.delete();
            exp_fetch   = bus.redirect_pc;
            halt_popped = 1'b0;
        end
    endtask

    task automatic redirect_to(input logic [AW-1:0] pc);
        t_redirect = 1'b1;
        t_rpc      = pc;
        step();
        t_redirect = 1'b0;
    endtask

    initial begin
        int p;
        t_rst = 1'b1; t_redirect = 1'b0; t_rpc = '0; t_stall = 1'b0; t_ready = 1'b1;
        lat = 1; cyc = 0; exp_fetch = '0; max_addr = '0; halt_popped = 1'b0;
        first_valid = -1; n_pops = 0; last_pc = '0; last_pc_next = '0; last_halt = 1'b0;
        rst = 1'b1;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.stall = 1'b0;
        bus.imem_ready = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;

        // Reset state
        repeat (3) step();
        check_zero("reset");

        // Straight-line fetch, latency 1, always ready
        t_rst = 1'b0;
        cyc = 0;
        repeat (12) step();
        check("t1_first_valid_cycle", 32'(first_valid), 3);
        check("t1_pop_count",         32'(n_pops),      10);

        // Decode stall fills the queue to DEPTH and stops issue
        t_stall = 1'b1;
        repeat (10) step();
        check("t2_queued",   32'(sb.size()),    4);
        check("t2_req_low",  32'(bus.imem_req), 0);
        check("t2_valid",    32'(bus.id_valid), 1);
        t_stall = 1'b0;
        repeat (15) step();

        // Random stall / ready with latency 2
        lat = 2;
        for (int i = 0; i < 150; i++) begin
            t_stall = ($urandom_range(0, 2) == 0);
            t_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        t_stall = 1'b0;
        t_ready = 1'b1;

        // Redirect with two requests in flight, latency 3
        lat = 3;
        for (int i = 0; i < 50 && pend.size() != 2; i++) step();
        check("t3_two_outstanding", 32'(pend.size()), 2);
        redirect_to(16'h0040);
        check("t3_redirect_req", 32'(bus.imem_req), 0);
        step();
        check("t3_flush_empty", 32'(bus.id_valid), 0);
        p = n_pops;
        for (int i = 0; i < 50 && n_pops == p; i++) step();
        check("t3_first_pc", 32'(last_pc), 32'h40);
        repeat (10) step();

        // Halt on all-zero instruction at 0x8
        mem[8] = '0;
        lat = 2;
        redirect_to(16'h0000);
        max_addr = '0;
        for (int i = 0; i < 100 && !halt_popped; i++) step();
        check("t4_halt_seen", 32'(halt_popped), 1);
        check("t4_halt_pc",   32'(last_pc),     32'h8);
        check("t4_id_halt",   32'(last_halt),   1);
        repeat (10) step();
        check("t4_req_bound", 32'(max_addr <= 16'h000C), 1);
        redirect_to(16'h0000);
        p = n_pops;
        for (int i = 0; i < 50 && n_pops == p; i++) step();
        check("t4_restart_pc", 32'(last_pc), 0);
        for (int i = 0; i < 100 && !halt_popped; i++) step();
        check("t4_halt_again", 32'(halt_popped), 1);
        mem.delete(8);

        // PC wrap sets sticky overflow
        check("t5_ovf_before", 32'(bus.pc_ovf), 0);
        mem[16'hFFFE] = 16'd5;
        lat = 1;
        redirect_to(16'hFFFE);
        p = n_pops;
        for (int i = 0; i < 50 && n_pops == p; i++) step();
        check("t5_pc",      32'(last_pc),      32'hFFFE);
        check("t5_pc_next", 32'(last_pc_next), 0);
        repeat (5) step();
        check("t5_ovf_set", 32'(bus.pc_ovf), 1);
        t_redirect = 1'b1;
        t_rpc = 16'h0100;
        step();
        t_rpc = 16'h0120;
        step();
        t_redirect = 1'b0;
        p = n_pops;
        for (int i = 0; i < 50 && n_pops == p; i++) step();
        check("t5_b2b_last_wins", 32'(last_pc), 32'h120);
        repeat (10) step();
        check("t5_ovf_sticky", 32'(bus.pc_ovf), 1);

        // Asynchronous reset mid-burst
        lat = 3;
        t_stall = 1'b1;
        redirect_to(16'h0300);
        for (int i = 0; i < 50 && !(pend.size() == 2 && sb.size() >= 3); i++) step();
        check("t6_burst_state", 32'(pend.size() == 2 && sb.size() >= 3), 1);
        #2;
        rst   = 1'b1;
        t_rst = 1'b1;
        #1;
        check_zero("t6_async");
        pend.delete();
        sb.delete();
        exp_fetch   = '0;
        halt_popped = 1'b0;
        repeat (3) step();
        t_stall = 1'b0;
        t_rst   = 1'b0;
        lat = 1;
        first_valid = -1;
        cyc = 0;
        repeat (8) step();
        check("t6_restart_first_valid", 32'(first_valid), 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
